// File: rtl/mk14_uart_dump.sv
// MK14 memory dump transmitter: streams a block of memory out of the TX pin as 8N1 serial.
// It shares a read_en/addr/data memory port with the rest of the SoC.
module mk14_uart_dump #(
  parameter int CLOCK_FREQ_MHZ = 27,
  parameter int BAUD_RATE      = 115200,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [15:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic                  tx_wait,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic                  tx
);

  localparam int DIV   = (CLOCK_FREQ_MHZ * 1000000) / BAUD_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    LATCH,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [15:0]             remaining;
  logic [7:0]              shift_reg;
  logic [2:0]              bit_idx;
  logic [CNT_W-1:0]        baud_cnt;
  logic                    bit_end;
  logic                    counting;

  assign counting = (state == START) || (state == DATA) || (state == STOP);
  assign bit_end  = counting && (baud_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = CHECK;
      CHECK: state_next = (remaining == 16'd0) ? DONE : FETCH;
      FETCH: state_next = LATCH;
      LATCH: state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      // remaining still holds the pre-decrement count here, so 1 means this was the last byte
      STOP:  if (bit_end) state_next = (remaining == 16'd1) ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: transfer bookkeeping, bit timing and the byte being shifted out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
      shift_reg <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      mem_addr  <= '0;
    end else begin
      if (!counting || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if ((state == IDLE) && start) begin
        addr      <= start_addr;
        remaining <= length;
      end

      if (state == LATCH) begin
        shift_reg <= mem_data;
        bit_idx   <= '0;
      end

      if ((state == DATA) && bit_end) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
        bit_idx   <= bit_idx + 1'b1;
      end

      if ((state == STOP) && bit_end) begin
        remaining <= remaining - 1'b1;
        addr      <= addr + 1'b1;
      end

      // mem_addr only moves when a fetch is about to happen, so it holds between reads
      if (state_next == FETCH) begin
        mem_addr <= (state == STOP) ? addr + 1'b1 : addr;
      end
    end
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_read_en = 1'b0;
    tx          = 1'b1;
    unique case (state)
      IDLE:  ;
      CHECK: busy = 1'b1;
      FETCH: begin
        busy        = 1'b1;
        mem_read_en = 1'b1;
      end
      LATCH: busy = 1'b1;
      START: begin
        busy = 1'b1;
        tx   = 1'b0;
      end
      DATA: begin
        busy = 1'b1;
        tx   = shift_reg[0];
      end
      STOP:  busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign tx_wait = busy;

endmodule

// File: tb/tb_mk14_uart_dump.sv
// Self-checking bench for mk14_uart_dump: a memory model, UART line decoder and
// read/byte scoreboards fed by a transfer-level model of the dump.
module tb_mk14_uart_dump;

  localparam int DIV      = (27 * 1000000) / 115200;
  localparam int BYTE_CYC = 10 * DIV + 2;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        start      = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] length     = '0;
  logic        busy;
  logic        done;
  logic        tx_wait;
  logic        mem_read_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data   = '0;
  logic        tx;

  logic [7:0]  mem [0:65535];

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int issue_cyc  = 0;
  int exp_done   = 0;
  int done_count = 0;
  bit rst_seen   = 1'b0;

  logic [15:0] exp_addr_q[$];
  logic [7:0]  exp_byte_q[$];
  int          start_cyc_q[$];

  mk14_uart_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .tx_wait    (tx_wait),
    .mem_read_en(mem_read_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data appears the cycle after the read strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read_en) mem_data <= mem[mem_addr];
  end

  always @(negedge rst_n) rst_seen = 1'b1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_unexpected(input string name, input int act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Read-port and done monitors
  always @(negedge clk) begin
    if (rst_n && mem_read_en) begin
      if (exp_addr_q.size() == 0) report_unexpected("unexpected_read", int'(mem_addr));
      else check_output("read_addr", int'(mem_addr), int'(exp_addr_q.pop_front()));
    end
    if (rst_n && done) done_count++;
  end

  // Line decoder: samples each bit at its centre and scores the byte
  initial begin : uart_monitor
    logic [7:0] rx;
    logic       start_bit;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (rst_n && (tx === 1'b0)) begin
        rst_seen = 1'b0;
        start_cyc_q.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        start_bit = tx;
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          rx[b] = tx;
        end
        repeat (DIV) @(negedge clk);
        stop_bit = tx;
        if (!rst_seen) begin
          check_output("start_bit", int'(start_bit), 0);
          check_output("stop_bit", int'(stop_bit), 1);
          if (exp_byte_q.size() == 0) report_unexpected("unexpected_frame", int'(rx));
          else check_output("rx_byte", int'(rx), int'(exp_byte_q.pop_front()));
        end
      end
    end
  end

  // Issue a transfer from IDLE and record what the line and read port must show
  task automatic apply_stimulus(input logic [15:0] addr, input int len);
    logic [15:0] a;
    start_addr = addr;
    length     = 16'(len);
    start      = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    issue_cyc = cyc;
    check_output("busy_in_check", int'(busy), 1);
    check_output("tx_wait_in_check", int'(tx_wait), 1);
    for (int i = 0; i < len; i++) begin
      a = addr + 16'(i);
      exp_addr_q.push_back(a);
      exp_byte_q.push_back(mem[a]);
    end
    exp_done++;
  endtask

  task automatic wait_done(input int len);
    int limit;
    bit seen;
    limit = len * BYTE_CYC + 20;
    seen  = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) report_unexpected("done_timeout", len);
    else check_output("done_latency", cyc - issue_cyc, 1 + len * BYTE_CYC);
    @(negedge clk);
    check_output("busy_after_done", int'(busy), 0);
    check_output("tx_wait_after_done", int'(tx_wait), 0);
  endtask

  task automatic wait_tx_low(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    if (!seen) report_unexpected("tx_fall_timeout", limit);
  endtask

  initial begin : watchdog
    #(10 * 95000);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    logic [15:0] ra;
    int rl;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0F00] = 8'h55;
    mem[16'hFFFF] = 8'hA5;
    mem[16'h0000] = 8'h3C;

    repeat (3) @(negedge clk);
    #1;
    check_output("reset_tx", int'(tx), 1);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_tx_wait", int'(tx_wait), 0);
    check_output("reset_mem_read_en", int'(mem_read_en), 0);
    check_output("reset_mem_addr", int'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] single byte 0x55 at 0x0F00");
    apply_stimulus(16'h0F00, 1);
    wait_done(1);
    n = start_cyc_q.size();
    if (n < 1) report_unexpected("no_frame_seen", 0);
    else check_output("tx_fall_to_done", (issue_cyc + 1 + BYTE_CYC) - start_cyc_q[n-1], 10 * DIV);

    $display("[TB] zero length at 0x0200");
    apply_stimulus(16'h0200, 0);
    wait_done(0);
    check_output("tx_idle_after_zero_len", int'(tx), 1);

    $display("[TB] address wrap 0xFFFF, two bytes");
    apply_stimulus(16'hFFFF, 2);
    wait_done(2);
    n = start_cyc_q.size();
    if (n < 2) report_unexpected("wrap_frames_missing", n);
    else check_output("frame_spacing", start_cyc_q[n-1] - start_cyc_q[n-2], BYTE_CYC);

    $display("[TB] start ignored while busy");
    apply_stimulus(16'h0100, 2);
    repeat (500) @(negedge clk);
    start_addr = 16'h1234;
    length     = 16'd5;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2);

    $display("[TB] reset during data bit 4");
    apply_stimulus(16'h0400, 1);
    wait_tx_low(10);
    repeat (5 * DIV + DIV / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_tx", int'(tx), 1);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done", int'(done), 0);
    exp_byte_q.delete();
    exp_addr_q.delete();
    exp_done--;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2600) @(negedge clk);
    apply_stimulus(16'h0300, 1);
    wait_done(1);

    $display("[TB] back-to-back transfers");
    apply_stimulus(16'($urandom), 3);
    wait_done(3);
    apply_stimulus(16'($urandom), 3);
    wait_done(3);

    $display("[TB] random transfers");
    for (int t = 0; t < 2; t++) begin
      ra = 16'($urandom_range(0, 65535));
      rl = $urandom_range(0, 2);
      apply_stimulus(ra, rl);
      wait_done(rl);
    end

    repeat (50) @(negedge clk);
    check_output("done_count", done_count, exp_done);
    check_output("bytes_outstanding", exp_byte_q.size(), 0);
    check_output("reads_outstanding", exp_addr_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
